pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have these ports, one clock domain, reset asynchronous active-low:
- clk  in  1  rising-edge clock
- nrst  in  1  asynchronous active-low reset
- pwm_in  in  1  PWM waveform, asynchronous to clk
- en  in  1  measurement enable, level
- top  out  16  measured period minus 1, in clk cycles
- cmp  out  16  measured high time, in clk cycles
- valid  out  1  one-cycle pulse: top/cmp updated this cycle
- ovf  out  1  sticky: no edge within 65535 cycles
REQ-002 The block SHALL have no parameters; all widths are fixed at 16 bits.

Function
REQ-003 pwm_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-004 The FSM SHALL have states IDLE, SYNC, HIGH and LOW, plus a 16-bit cycle counter cnt and a 16-bit high-time register hcnt.
REQ-005 In any state, en=0 SHALL force a transition to IDLE on the next edge, with no valid pulse and top/cmp held.
REQ-006 IDLE with en=1 SHALL go to SYNC.
REQ-007 SYNC SHALL ignore fall; on rise: cnt<=1, go to HIGH.
REQ-008 HIGH on fall SHALL set hcnt<=cnt and cnt<=cnt+1, then go to LOW; with no edge, cnt<=cnt+1.
REQ-009 LOW on rise SHALL set top<=cnt-1, cmp<=hcnt, valid<=1, cnt<=1, then go to HIGH; with no edge, cnt<=cnt+1.
REQ-010 The first rise after SYNC only starts a measurement; the first valid SHALL come on the second synchronized rise.
REQ-011 In HIGH or LOW, if cnt==16'hFFFF and no qualifying edge occurs: ovf<=1, go to SYNC, no valid, top/cmp held; cnt SHALL never wrap.
REQ-012 The measurable range is period 2..65535 cycles and high time 1..period-1; constant-level input (0% or 100% duty) SHALL report only via ovf.
REQ-013 ovf SHALL be cleared only by reset or by en=0; it SHALL stay set across later valid measurements.
REQ-014 valid SHALL be high for exactly one cycle per measured period and low at all other times.
REQ-015 Latency: pwm_in rising before clk edge k SHALL produce valid high in the cycle after edge k+2, i.e. 3 edges.
REQ-016 When the input comes from a same-clock PWM generator (counter 0..T, out = cnt<C, 0<C<=T), the block SHALL report top=T, cmp=C.
REQ-017 rise and fall are mutually exclusive per cycle by construction; no simultaneous-edge priority SHALL be needed.

Reset
REQ-018 With nrst=0, s1/s2/s3, cnt, hcnt, top, cmp, valid and ovf SHALL be 0 and the FSM SHALL be in IDLE, independent of clk.
REQ-019 After nrst deasserts mid-waveform, the block SHALL restart from IDLE/SYNC and discard any partial period.

Verification
REQ-020 en=1, generator T=9, C=3 -> valid every 10 cycles with top=9, cmp=3; first valid on the second rise.
REQ-021 Generator T=1, C=1 (period 2, high 1) -> top=1, cmp=1, valid every 2 cycles.
REQ-022 pwm_in held at 0, then held at 1 (T=4, C=7), for 70000 cycles each -> no valid; ovf=1 after 65535 cycles without an edge; top/cmp keep their previous values.
REQ-023 T=99, C=40, en dropped at cycle 50 of a period, re-raised 5 cycles later -> no spurious valid; next valid after two rises reports top=99, cmp=40; ovf cleared.
REQ-024 nrst pulsed low mid-HIGH while measuring T=19, C=5 -> all outputs 0 immediately; after release, correct top=19, cmp=5 on the second rise.
REQ-025 Change from T=9, C=3 to T=29, C=12 at a period boundary -> one valid reports 9/3, the following valid reports 29/12, with no intermediate mixed values.

Source files
------------

// File: rtl/pwm_capture.sv
// ============================================================================
//  Module      : pwm_capture
//  Description : Measures period (as top = period-1) and high time of an
//                asynchronous PWM input, in clk cycles, with overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture (
   input  logic        clk,
   input  logic        nrst,
   input  logic        pwm_in,
   input  logic        en,
   output logic [15:0] top,
   output logic [15:0] cmp,
   output logic        valid,
   output logic        ovf
);

   localparam logic [1:0]  c_IDLE    = 2'd0;
   localparam logic [1:0]  c_SYNC    = 2'd1;
   localparam logic [1:0]  c_HIGH    = 2'd2;
   localparam logic [1:0]  c_LOW     = 2'd3;
   localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

   logic        r_s1, r_s2, r_s3;
   logic        w_rise, w_fall;
   logic [1:0]  r_state, w_state_nxt;
   logic [15:0] r_cnt, w_cnt_nxt;
   logic [15:0] r_hcnt, w_hcnt_nxt;
   logic [15:0] r_top, w_top_nxt;
   logic [15:0] r_cmp, w_cmp_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_ovf, w_ovf_nxt;
   logic        w_cnt_max;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= pwm_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise    = r_s2 & ~r_s3;
   assign w_fall    = ~r_s2 & r_s3;
   assign w_cnt_max = (r_cnt == c_CNT_MAX);

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (!en) begin
         w_state_nxt = c_IDLE;
      end else begin
         case (r_state)
            c_IDLE: w_state_nxt = c_SYNC;
            c_SYNC: if (w_rise) w_state_nxt = c_HIGH;
            c_HIGH: begin
               if (w_fall)         w_state_nxt = c_LOW;
               else if (w_cnt_max) w_state_nxt = c_SYNC;
            end
            c_LOW: begin
               if (w_rise)         w_state_nxt = c_HIGH;
               else if (w_cnt_max) w_state_nxt = c_SYNC;
            end
            default: w_state_nxt = c_IDLE;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_hcnt_nxt  = r_hcnt;
      w_top_nxt   = r_top;
      w_cmp_nxt   = r_cmp;
      w_valid_nxt = 1'b0;
      w_ovf_nxt   = r_ovf;
      if (!en) begin
         w_cnt_nxt = 16'd0;
         w_ovf_nxt = 1'b0;
      end else begin
         case (r_state)
            c_SYNC: if (w_rise) w_cnt_nxt = 16'd1;
            c_HIGH: begin
               if (w_fall) begin
                  w_hcnt_nxt = r_cnt;
                  // Saturate so an over-long high phase still ends in overflow
                  w_cnt_nxt  = w_cnt_max ? r_cnt : r_cnt + 16'd1;
               end else if (w_cnt_max) begin
                  w_ovf_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 16'd1;
               end
            end
            c_LOW: begin
               if (w_rise) begin
                  w_top_nxt   = r_cnt - 16'd1;
                  w_cmp_nxt   = r_hcnt;
                  w_valid_nxt = 1'b1;
                  w_cnt_nxt   = 16'd1;
               end else if (w_cnt_max) begin
                  w_ovf_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt   <= 16'd0;
         r_hcnt  <= 16'd0;
         r_top   <= 16'd0;
         r_cmp   <= 16'd0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_hcnt  <= w_hcnt_nxt;
         r_top   <= w_top_nxt;
         r_cmp   <= w_cmp_nxt;
         r_valid <= w_valid_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   assign top   = r_top;
   assign cmp   = r_cmp;
   assign valid = r_valid;
   assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
//  Module      : tb_pwm_capture
//  Description : Self-checking bench for pwm_capture using a timestamp model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_capture;

   logic        clk;
   logic        nrst;
   logic        pwm_in;
   logic        en;
   logic [15:0] top;
   logic [15:0] cmp;
   logic        valid;
   logic        ovf;

   pwm_capture dut (
      .clk    (clk),
      .nrst   (nrst),
      .pwm_in (pwm_in),
      .en     (en),
      .top    (top),
      .cmp    (cmp),
      .valid  (valid),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // ------------------------------------------------------------------
   // Model: the input as the block sees it arrives two cycles late; a
   // measurement is the distance between consecutive rise timestamps.
   // ------------------------------------------------------------------
   localparam int M_OFF = 0;
   localparam int M_ARM = 1;
   localparam int M_RUN = 2;

   logic [2:0]  m_h;
   int          m_mode;
   int          t0, tf;
   logic        fseen;
   logic [15:0] m_top, m_cmp;
   logic        m_valid, m_ovf;
   logic        m_rise, m_fall;

   assign m_rise = m_h[1] & ~m_h[2];
   assign m_fall = ~m_h[1] & m_h[2];

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_h <= 3'b000; m_mode <= M_OFF; t0 <= 0; tf <= 0; fseen <= 1'b0;
         m_top <= 16'd0; m_cmp <= 16'd0; m_valid <= 1'b0; m_ovf <= 1'b0;
      end else begin
         m_h     <= {m_h[1:0], pwm_in};
         m_valid <= 1'b0;
         if (!en) begin
            m_mode <= M_OFF;
            m_ovf  <= 1'b0;
         end else if (m_mode == M_OFF) begin
            m_mode <= M_ARM;
         end else if (m_mode == M_ARM) begin
            if (m_rise) begin t0 <= cyc; fseen <= 1'b0; m_mode <= M_RUN; end
         end else begin
            if (m_rise && fseen) begin
               m_top   <= 16'(cyc - t0 - 1);
               m_cmp   <= 16'(tf - t0);
               m_valid <= 1'b1;
               t0      <= cyc;
               fseen   <= 1'b0;
            end else if (m_fall && !fseen) begin
               tf <= cyc; fseen <= 1'b1;
            end else if (cyc - t0 >= 65535) begin
               m_ovf  <= 1'b1;
               m_mode <= M_ARM;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("valid", {31'd0, valid}, {31'd0, m_valid});
         check("ovf",   {31'd0, ovf},   {31'd0, m_ovf});
         check("top",   {16'd0, top},   {16'd0, m_top});
         check("cmp",   {16'd0, cmp},   {16'd0, m_cmp});
      end
   end

   // Valid pulse monitor
   int vcnt = 0;
   int last_vcyc = 0;
   int last_rise = 0;
   int lat = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (valid === 1'b1) begin
            vcnt++;
            last_vcyc = cyc;
            lat = cyc - last_rise;
         end
      end
   end

   // Same-clock generator: counter 0..gT, output = counter < gC
   int   gT = 9, gC = 3, gcnt = 0;
   logic p_prev = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      pwm_in = (gcnt < gC);
      if (pwm_in && !p_prev) last_rise = cyc;
      p_prev = pwm_in;
      gcnt = (gcnt >= gT) ? 0 : gcnt + 1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_gcnt(input int v);
      for (int i = 0; i < 300; i++) begin
         if (gcnt == v) return;
         tick();
      end
      check("wait_gcnt_timeout", 32'd0, 32'd1);
   endtask

   task automatic set_gen(input int t, input int c);
      wait_gcnt(0);
      gT = t;
      gC = c;
   endtask

   task automatic wait_valid(input int maxc);
      int v0;
      v0 = vcnt;
      for (int i = 0; i < maxc; i++) begin
         tick();
         if (vcnt != v0) return;
      end
      check("wait_valid_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   int r1, v1, e, rel, v0;

   initial begin
      pwm_in = 1'b0;
      en     = 1'b0;
      nrst   = 1'b1;
      #1 nrst = 1'b0;
      #2;
      check("rst_top",   {16'd0, top}, 32'd0);
      check("rst_cmp",   {16'd0, cmp}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_ovf",   {31'd0, ovf}, 32'd0);
      ticks(3);
      nrst = 1'b1;

      // T=9, C=3: first valid on the second rise, 3-edge latency
      ticks(20);
      check("no_valid_when_disabled", vcnt, 0);
      wait_gcnt(5);
      en = 1'b1;
      r1 = last_rise;
      for (int i = 0; i < 50 && last_rise == r1; i++) tick();
      r1 = last_rise;
      wait_valid(100);
      check("first_valid_after_first_rise", last_vcyc - r1, 13);
      check("t9_top", {16'd0, top}, 32'd9);
      check("t9_cmp", {16'd0, cmp}, 32'd3);
      check("latency", lat, 3);
      v1 = last_vcyc;
      wait_valid(100);
      check("t9_spacing", last_vcyc - v1, 10);
      v0 = vcnt;
      ticks(50);
      check("t9_count_50", vcnt - v0, 5);

      // Period-boundary switch to T=29, C=12
      set_gen(29, 12);
      wait_valid(100);
      check("switch_old_top", {16'd0, top}, 32'd9);
      check("switch_old_cmp", {16'd0, cmp}, 32'd3);
      wait_valid(100);
      check("switch_new_top", {16'd0, top}, 32'd29);
      check("switch_new_cmp", {16'd0, cmp}, 32'd12);

      // Minimum period: T=1, C=1
      set_gen(1, 1);
      wait_valid(100);
      wait_valid(100);
      check("t1_top", {16'd0, top}, 32'd1);
      check("t1_cmp", {16'd0, cmp}, 32'd1);
      v1 = last_vcyc;
      wait_valid(100);
      check("t1_spacing", last_vcyc - v1, 2);

      // Constant low, then constant high: overflow only
      gT = 4; gC = 0;
      ticks(10);
      v0 = vcnt;
      ticks(60000);
      check("ovf_not_early", {31'd0, ovf}, 32'd0);
      ticks(5600);
      check("ovf_low", {31'd0, ovf}, 32'd1);
      check("no_valid_low", vcnt - v0, 0);
      check("held_top", {16'd0, top}, 32'd1);
      check("held_cmp", {16'd0, cmp}, 32'd1);
      gT = 4; gC = 7;
      ticks(2000);
      check("no_valid_high", vcnt - v0, 0);
      check("ovf_sticky", {31'd0, ovf}, 32'd1);

      // T=99, C=40 with an enable drop mid-period
      gT = 99; gC = 40; gcnt = 0;
      en = 1'b0;
      tick();
      check("ovf_cleared_by_en", {31'd0, ovf}, 32'd0);
      en = 1'b1;
      wait_valid(400);
      check("t99_top", {16'd0, top}, 32'd99);
      check("t99_cmp", {16'd0, cmp}, 32'd40);
      wait_gcnt(50);
      en = 1'b0;
      v0 = vcnt;
      ticks(5);
      en = 1'b1;
      e = cyc;
      check("no_valid_en_low", vcnt - v0, 0);
      wait_valid(400);
      check("en_rearm_two_rises", {31'd0, (last_vcyc - e) > 100}, 32'd1);
      check("t99_top_after_en", {16'd0, top}, 32'd99);
      check("t99_cmp_after_en", {16'd0, cmp}, 32'd40);
      check("t99_ovf", {31'd0, ovf}, 32'd0);

      // T=19, C=5 with a reset pulse while high
      set_gen(19, 5);
      wait_valid(200);
      wait_valid(200);
      check("t19_top", {16'd0, top}, 32'd19);
      check("t19_cmp", {16'd0, cmp}, 32'd5);
      wait_gcnt(5);
      #2 nrst = 1'b0;
      #1;
      check("arst_top",   {16'd0, top}, 32'd0);
      check("arst_cmp",   {16'd0, cmp}, 32'd0);
      check("arst_valid", {31'd0, valid}, 32'd0);
      check("arst_ovf",   {31'd0, ovf}, 32'd0);
      ticks(2);
      nrst = 1'b1;
      rel = cyc;
      wait_valid(200);
      check("t19_restart_two_rises", {31'd0, (last_vcyc - rel) >= 20}, 32'd1);
      check("t19_top_after_rst", {16'd0, top}, 32'd19);
      check("t19_cmp_after_rst", {16'd0, cmp}, 32'd5);
      ticks(5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
